// File: rtl/bin_add3_arbiter.sv
// bin_add3_arbiter: round-robin arbiter that time-shares one registered
// 3-input adder among NUM_REQ requesters and presents the sum, together with
// the index of the requester that produced it, on a valid/ready result port.
// Optional feature: define BIN_ADD3_ARB_LOCK_EN to add the per-requester lock
// input, which lets a winner keep exclusive ownership of the adder.
module bin_add3_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ),
  parameter int OPA_WIDTH = 18,
  parameter int OPB_WIDTH = 18,
  parameter int OPC_WIDTH = 18,
  parameter int OUT_WIDTH = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*OPA_WIDTH-1:0]   in_a,
  input  logic [NUM_REQ*OPB_WIDTH-1:0]   in_b,
  input  logic [NUM_REQ*OPC_WIDTH-1:0]   in_c,
`ifdef BIN_ADD3_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             lock,
`endif
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [OUT_WIDTH-1:0]           res_sum,
  output logic [IDX_WIDTH-1:0]           res_id
);

  // Full-precision width of the raw sum before it is fitted to OUT_WIDTH.
  localparam int MAX_AB = (OPA_WIDTH > OPB_WIDTH) ? OPA_WIDTH : OPB_WIDTH;
  localparam int MAX_W  = (MAX_AB > OPC_WIDTH) ? MAX_AB : OPC_WIDTH;
  localparam int FULL_W = MAX_W + 2;

  // Unsigned sum of three zero-extended operands, wrapped modulo 2^OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] add3_wrap(
    input logic [OPA_WIDTH-1:0] a,
    input logic [OPB_WIDTH-1:0] b,
    input logic [OPC_WIDTH-1:0] c
  );
    logic [FULL_W-1:0] s;
    s = FULL_W'(a) + FULL_W'(b) + FULL_W'(c);
    return OUT_WIDTH'(s);
  endfunction

  logic                 vld_p1;
  logic [OUT_WIDTH-1:0] sum_p1;
  logic [IDX_WIDTH-1:0] id_p1;
  logic [IDX_WIDTH-1:0] rr_ptr;

  logic                 slot_free;
  logic                 win_vld;
  logic                 grant_en;
  logic [IDX_WIDTH-1:0] win_idx;
  logic [IDX_WIDTH-1:0] nxt_ptr;
  logic [NUM_REQ-1:0]   req_eff;
  logic [OPA_WIDTH-1:0] op_a_p0;
  logic [OPB_WIDTH-1:0] op_b_p0;
  logic [OPC_WIDTH-1:0] op_c_p0;

  assign slot_free = !vld_p1 || res_ready;

`ifdef BIN_ADD3_ARB_LOCK_EN
  logic                 own_vld;
  logic [IDX_WIDTH-1:0] own_idx;
  logic                 own_hold;

  // An owner only excludes others while it is still requesting.
  assign own_hold = own_vld && req[own_idx];

  // Restrict the candidate set to the owner while ownership is in force.
  always_comb begin
    req_eff = req;
    if (own_hold) req_eff = NUM_REQ'(1) << own_idx;
  end

  // Track lock ownership: taken/renewed/released on a grant, dropped with req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_vld <= 1'b0;
      own_idx <= '0;
    end else if (grant_en) begin
      own_vld <= lock[win_idx];
      own_idx <= win_idx;
    end else if (own_vld && !req[own_idx]) begin
      own_vld <= 1'b0;
    end
  end
`else
  assign req_eff = req;
`endif

  // Pick the first requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_vld && req_eff[j]) begin
        win_vld = 1'b1;
        win_idx = IDX_WIDTH'(j);
      end
    end
  end

  // Grant only into a free slot and never while reset is asserted.
  always_comb begin
    grant_en = rst_n && slot_free && win_vld;
    gnt      = '0;
    if (grant_en) gnt = NUM_REQ'(1) << win_idx;
    nxt_ptr  = (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + IDX_WIDTH'(1);
    op_a_p0  = in_a[int'(win_idx)*OPA_WIDTH +: OPA_WIDTH];
    op_b_p0  = in_b[int'(win_idx)*OPB_WIDTH +: OPB_WIDTH];
    op_c_p0  = in_c[int'(win_idx)*OPC_WIDTH +: OPC_WIDTH];
  end

  // ---- stage p0 -> p1: register the winner's sum, index and valid ----
  // Result register; loads on a grant, empties when consumed with no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
      id_p1  <= '0;
    end else if (slot_free) begin
      if (grant_en) begin
        vld_p1 <= 1'b1;
        sum_p1 <= add3_wrap(op_a_p0, op_b_p0, op_c_p0);
        id_p1  <= win_idx;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Round-robin pointer; a locking winner keeps the pointer on itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_en) begin
`ifdef BIN_ADD3_ARB_LOCK_EN
      rr_ptr <= lock[win_idx] ? win_idx : nxt_ptr;
`else
      rr_ptr <= nxt_ptr;
`endif
    end
  end

  assign res_valid = vld_p1;
  assign res_sum   = sum_p1;
  assign res_id    = id_p1;

endmodule

// File: tb/tb_bin_add3_arbiter.sv
// Testbench for bin_add3_arbiter: reference model plus result scoreboard,
// directed scenarios (reset, single op, widths, fairness, backpressure, lock)
// followed by a random phase. A second instance uses OUT_WIDTH=18.
module tb_bin_add3_arbiter;
  localparam int N = 4;
  localparam int W = 18;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_a, in_b, in_c;
  logic [N-1:0]   lock;
  logic [N-1:0]   gnt, gnt18;
  logic           res_valid, res_valid18;
  logic           res_ready;
  logic [19:0]    res_sum;
  logic [17:0]    res_sum18;
  logic [1:0]     res_id, res_id18;

  bin_add3_arbiter #(.NUM_REQ(N), .OUT_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_a(in_a), .in_b(in_b), .in_c(in_c),
`ifdef BIN_ADD3_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id)
  );

  bin_add3_arbiter #(.NUM_REQ(N), .OUT_WIDTH(18)) dut18 (
    .clk(clk), .rst_n(rst_n), .req(req), .in_a(in_a), .in_b(in_b), .in_c(in_c),
`ifdef BIN_ADD3_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt18), .res_valid(res_valid18), .res_ready(res_ready),
    .res_sum(res_sum18), .res_id(res_id18)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    longint s20;
    longint s18;
    int     id;
  } exp_t;
  exp_t q[$];

  // Reference model state
  bit m_valid   = 1'b0;
  int m_ptr     = 0;
  bit m_own_vld = 1'b0;
  int m_own     = 0;

  // Model evaluated mid-cycle; its updates represent the coming rising edge.
  always @(negedge clk) begin
    int     win;
    bit     free;
    logic [N-1:0] eff;
    logic [N-1:0] eg;
    longint av, bv, cv;
    exp_t   e;
    if (!rst_n) begin
      m_valid = 1'b0; m_ptr = 0; m_own_vld = 1'b0; m_own = 0;
      q.delete();
      chk("rst_gnt", gnt, 0);
      chk("rst_vld", res_valid, 0);
    end else begin
      free = !m_valid || res_ready;
      eff  = req;
`ifdef BIN_ADD3_ARB_LOCK_EN
      if (m_own_vld && req[m_own]) eff = 4'b0001 << m_own;
      else if (m_own_vld) m_own_vld = 1'b0;
`endif
      win = -1;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && eff[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
      end
      eg = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      chk("gnt", gnt, eg);
      chk("gnt18", gnt18, eg);
      chk("res_valid", res_valid, m_valid);
      if (m_valid) begin
        if (q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          chk("res_sum", res_sum, q[0].s20);
          chk("res_sum18", res_sum18, q[0].s18);
          chk("res_id", res_id, q[0].id);
          if (res_ready) void'(q.pop_front());
        end
      end
      if (win >= 0) begin
        av = longint'(in_a[win*W +: W]);
        bv = longint'(in_b[win*W +: W]);
        cv = longint'(in_c[win*W +: W]);
        e.s20 = (av + bv + cv) & 64'hFFFFF;
        e.s18 = (av + bv + cv) & 64'h3FFFF;
        e.id  = win;
        q.push_back(e);
        m_valid = 1'b1;
        m_ptr   = (win + 1) % N;
`ifdef BIN_ADD3_ARB_LOCK_EN
        m_own_vld = lock[win];
        m_own     = win;
        if (lock[win]) m_ptr = win;
`endif
      end else if (free) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
    in_a[i*W +: W] = a;
    in_b[i*W +: W] = b;
    in_c[i*W +: W] = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [19:0] hold_sum;
  logic [1:0]  hold_id;

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; res_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0;
    step();
    do_reset();

    // Single operation
    set_op(0, 18'd1, 18'd2, 18'd3);
    req = 4'b0001;
    #1 chk("single_gnt", gnt, 4'b0001);
    step();
    req = '0;
    chk("single_vld", res_valid, 1);
    chk("single_sum", res_sum, 6);
    chk("single_id", res_id, 0);

    // Maximum operands: full width vs. wrapped width
    set_op(0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
    req = 4'b0001;
    step();
    req = '0;
    chk("wide_sum", res_sum, 786429);
    chk("wrap_sum", res_sum18, 262141);

    // Reset in the middle of a held result
    set_op(0, 18'd10, 18'd20, 18'd30);
    req = 4'b0001; res_ready = 1'b0;
    step();
    chk("pre_rst_vld", res_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vld", res_valid, 0);
    chk("arst_sum", res_sum, 0);
    chk("arst_id", res_id, 0);
    chk("arst_gnt", gnt, 0);
    step();
    step();
    rst_n = 1'b1; res_ready = 1'b1;
    #1 chk("rst_first_gnt", gnt, 4'b0001);
    step();
    req = '0;
    step();

    // Fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i * 100 + 1), W'(i + 7), W'(3 * i));
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("fair_gnt", gnt, 4'b0001 << (k % 4));
      step();
      chk("fair_id", res_id, k % 4);
    end

    // Backpressure with requests pending
    res_ready = 1'b0;
    #1 chk("bp_gnt", gnt, 0);
    hold_sum = res_sum;
    hold_id  = res_id;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_gnt_hold", gnt, 0);
      chk("bp_vld", res_valid, 1);
      chk("bp_sum", res_sum, hold_sum);
      chk("bp_id", res_id, hold_id);
    end
    res_ready = 1'b1;
    #1 chk("bp_resume", gnt, 4'b0100);
    step();
    req = '0;
    step();

`ifdef BIN_ADD3_ARB_LOCK_EN
    // Lock: requester 0 keeps the adder until it releases on a grant
    do_reset();
    req = 4'b1111; lock = 4'b0001;
    #1 chk("lock_g1", gnt, 4'b0001);
    step();
    #1 chk("lock_g2", gnt, 4'b0001);
    step();
    lock = 4'b0000;
    #1 chk("lock_g3", gnt, 4'b0001);
    step();
    #1 chk("lock_next", gnt, 4'b0010);
    step();
    req = '0;
    step();
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      req       = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      lock      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom), W'($urandom));
      step();
    end

    // Drain
    req = '0; lock = '0; res_ready = 1'b1;
    step();
    step();
    step();
    chk("sb_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bin_add3_arbiter.md
# bin_add3_arbiter

Round-robin arbiter and sequencer sharing one registered 3-input adder among NUM_REQ requesters. Each requester presents three operands under a req/gnt handshake. The block grants at most one requester per cycle and registers the sum with the winner's index. It drives a valid/ready result port toward the modular-arithmetic consumers that would otherwise each need a dedicated adder.

## Interface
- NUM_REQ, 4: number of requesters (2..16)
- IDX_WIDTH, $clog2(NUM_REQ): width of requester index
- OPA_WIDTH, 18: operand A width
- OPB_WIDTH, 18: operand B width
- OPC_WIDTH, 18: operand C width
- OUT_WIDTH, 20: result width
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request
- in_a  in  NUM_REQ*OPA_WIDTH  operand A; requester i at bits [i*OPA_WIDTH +: OPA_WIDTH]
- in_b  in  NUM_REQ*OPB_WIDTH  operand B, same packing
- in_c  in  NUM_REQ*OPC_WIDTH  operand C, same packing
- lock  in  NUM_REQ  per-requester lock request (present only with BIN_ADD3_ARB_LOCK_EN)
- gnt  out  NUM_REQ  one-hot combinational grant; transfer occurs when req[i]&gnt[i]
- res_valid  out  1  result register holds an unconsumed sum
- res_ready  in  1  consumer accepts result
- res_sum  out  OUT_WIDTH  registered a+b+c of granted requester
- res_id  out  IDX_WIDTH  index of requester that produced res_sum

## Operation
- Slot free: slot_free = !res_valid | res_ready.
- Grant rules:
  - gnt is nonzero only when slot_free, rst_n=1 and some req is high.
  - The winner is the first requesting index at or after rr_ptr, scanning upward with wrap from NUM_REQ-1 to 0.
- On a grant to requester i:
  - res_sum <= zero-extended in_a[i] + in_b[i] + in_c[i], truncated modulo 2^OUT_WIDTH. No carry-out or saturation.
  - res_id <= i; res_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Slot free and no requester granted: res_valid <= 0; res_sum and res_id hold their last values.
- Slot not free (res_valid=1, res_ready=0): gnt=0, and all registers hold.
- Requester obligations:
  - Hold req and operands stable until granted.
  - Operands are sampled only on the grant cycle.
  - Dropping req before grant withdraws the request with no side effect.
- Reset:
  - res_valid=0, res_sum=0, res_id=0, rr_ptr=0, lock owner cleared.
  - gnt is forced 0 while rst_n=0.
  - A pending result is discarded; no partial transfer is reported.

## Timing
- Latency: result appears on res_valid/res_sum the cycle after the grant.
- Throughput: one sum per cycle while res_ready=1 and requests are pending.
- Simultaneous res_ready=1 with a new grant: the old result is consumed and the new sum loads on the same edge (no bubble).
- gnt is combinational from req, rr_ptr, res_valid and res_ready. Requesters must not make req depend combinationally on gnt.
- Reset deassertion: the first grant is possible in the first cycle with rst_n=1.

## Configuration
- BIN_ADD3_ARB_LOCK_EN defined:
  - lock port exists.
  - If the winner i has lock[i]=1 on its grant cycle, i becomes lock owner. While the owner holds req, only the owner is granted and rr_ptr stays at i.
  - Ownership ends on a grant to the owner with lock[i]=0, or when req[owner]=0. Round-robin then resumes from (i+1) mod NUM_REQ.
- Undefined:
  - No lock port and no owner register.
  - Pure round-robin as above.

## Test plan
- Reset: assert rst_n=0 mid-stream with res_valid=1 -> res_valid=0, res_sum=0, res_id=0, gnt=0 immediately; after release with req=0001, gnt=0001 on the first cycle.
- Single op: req=0001, a=1, b=2, c=3, res_ready=1 -> gnt=0001 at cycle N; at N+1 res_valid=1, res_sum=6, res_id=0.
- Width rules:
  - Defaults, all operands 18'h3FFFF -> res_sum=786429.
  - OUT_WIDTH=18, same operands -> res_sum=262141 (wrapped).
- Fairness: req=1111 held, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; res_id follows one cycle later.
- Backpressure:
  - res_valid=1 and res_ready=0 for 3 cycles -> gnt=0 and res_sum/res_id stable.
  - Raise res_ready -> the next grant occurs in that same cycle with no bubble.
- Lock (BIN_ADD3_ARB_LOCK_EN): req=1111, lock[0]=1 -> requester 0 granted 3 consecutive cycles; drop lock[0] on the third grant -> the next grant goes to 1.
